// File: rtl/mext_pkg.sv
// mext_pkg: shared operand width, M-extension multiply encodings and control FSM states
package mext_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
endpackage

// File: rtl/mul_core.sv
// mul_core: iterative unsigned shift-add multiplier, first partial product folded into the start cycle
module mul_core #(
  parameter int XLEN     = mext_pkg::XLEN,
  parameter int MUL_ITER = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] product
);
  localparam int CW = $clog2(MUL_ITER + 1);
  logic [2*XLEN-1:0] r_acc, r_mc;
  logic [XLEN-1:0] r_mp;
  logic [CW-1:0] r_cnt;
  logic r_busy, r_done;
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else if (start) begin
      r_acc  <= b[0] ? {{XLEN{1'b0}}, a} : '0;
      r_mc   <= {{(XLEN-1){1'b0}}, a, 1'b0};
      r_mp   <= b >> 1;
      r_cnt  <= CW'(MUL_ITER - 1);
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_acc  <= r_acc + (r_mp[0] ? r_mc : '0);
      r_mc   <= r_mc << 1;
      r_mp   <= r_mp >> 1;
      r_cnt  <= r_cnt - CW'(1);
      r_busy <= r_cnt != CW'(1);
      r_done <= r_cnt == CW'(1);
    end else begin
      r_done <= 1'b0;
    end
  end
  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_acc;
endmodule

// File: rtl/mext_mul_ctrl.sv
// mext_mul_ctrl: MUL/MULH/MULHSU/MULHU sequencer around mul_core with a one-entry operand cache
module mext_mul_ctrl import mext_pkg::*; #(
  parameter int XLEN     = mext_pkg::XLEN,
  parameter int MUL_ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  state_e r_state, w_next;
  logic [XLEN-1:0] r_rs1, r_rs2, r_c_rs1, r_c_rs2, w_a, w_b;
  logic [2:0] r_f3, r_c_f3;
  logic r_neg, r_cv;
  logic [2*XLEN-1:0] r_c_prod, w_prod, w_corr;
  logic w_acc, w_hit, w_n1, w_n2, w_start, w_abort, w_busy, w_cdone;
  assign w_acc   = r_state == S_IDLE && valid_i && !funct3_i[2];
  // low product bits do not depend on signedness, so a MUL can reuse any cached product
  assign w_hit   = r_cv && rs1_i == r_c_rs1 && rs2_i == r_c_rs2 &&
                   (funct3_i == r_c_f3 || funct3_i == OP_MUL);
  assign w_n1    = (funct3_i == OP_MULH || funct3_i == OP_MULHSU) && rs1_i[XLEN-1];
  assign w_n2    = funct3_i == OP_MULH && rs2_i[XLEN-1];
  assign w_a     = w_n1 ? -rs1_i : rs1_i;
  assign w_b     = w_n2 ? -rs2_i : rs2_i;
  assign w_start = w_acc && !w_hit;
  assign w_abort = r_state == S_CALC && flush_i;
  assign w_corr  = r_neg ? -w_prod : w_prod;
  mul_core #(.XLEN(XLEN), .MUL_ITER(MUL_ITER)) u_core (
    .clk(clk), .reset(reset), .start(w_start), .abort(w_abort),
    .a(w_a), .b(w_b), .busy(w_busy), .done(w_cdone), .product(w_prod)
  );
  always_comb begin
    w_next = r_state;
    if (r_state == S_IDLE) w_next = w_acc ? (w_hit ? S_DONE : S_CALC) : S_IDLE;
    else if (r_state == S_CALC) w_next = flush_i ? S_IDLE : (w_cdone && !w_busy) ? S_DONE : S_CALC;
    else w_next = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cv    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_rs1 <= rs1_i;
        r_rs2 <= rs2_i;
        r_f3  <= funct3_i;
        r_neg <= w_n1 ^ w_n2;
      end
      if (r_state == S_CALC && w_next == S_DONE) begin
        r_cv     <= 1'b1;
        r_c_rs1  <= r_rs1;
        r_c_rs2  <= r_rs2;
        r_c_f3   <= r_f3;
        r_c_prod <= w_corr;
      end
    end
  end
  assign stall_o  = w_acc || r_state == S_CALC;
  assign done_o   = r_state == S_DONE;
  assign result_o = !done_o ? '0 : r_f3 == OP_MUL ? r_c_prod[XLEN-1:0] : r_c_prod[2*XLEN-1:XLEN];
endmodule

// File: tb/tb_mext_mul_ctrl.sv
// tb_mext_mul_ctrl: directed checks of latency, results, cache hits, flush and reset
module tb_mext_mul_ctrl;
  logic clk = 1'b0, reset = 1'b1, valid_i = 1'b0, flush_i = 1'b0;
  logic [2:0] funct3_i = 3'b000;
  logic [31:0] rs1_i = '0, rs2_i = '0;
  logic stall_o, done_o;
  logic [31:0] result_o;
  int errs = 0, checks = 0, start_cnt = 0;

  mext_mul_ctrl #(.XLEN(32), .MUL_ITER(32)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .funct3_i(funct3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
    .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (dut.w_start === 1'b1) start_cnt++;

  // lat = cycle index of done_o with the accept cycle as 0; 0 if it never came
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic st0, output logic d1);
    @(negedge clk);
    valid_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b;
    #1 st0 = stall_o;
    @(posedge clk);
    #1 valid_i = 1'b0;
    lat = 0; res = 'x;
    for (int c = 1; c <= 60; c++) begin
      if (done_o === 1'b1) begin lat = c; res = result_o; break; end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1 d1 = done_o;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (stall_o !== 1'b0) begin errs++; $display("FAIL reset_stall got=%b want=0", stall_o); end
    checks++; if (done_o !== 1'b0) begin errs++; $display("FAIL reset_done got=%b want=0", done_o); end
    checks++; if (result_o !== 32'h0) begin errs++; $display("FAIL reset_result got=%h want=00000000", result_o); end
    reset = 1'b0;
  endtask

  task automatic test_divide_ignored;
    int s, d;
    s = start_cnt; d = 0;
    @(negedge clk);
    valid_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd6; rs2_i = 32'd3;
    #1;
    checks++; if (stall_o !== 1'b0) begin errs++; $display("FAIL div_stall got=%b want=0", stall_o); end
    repeat (5) begin @(posedge clk); #1 if (done_o !== 1'b0) d++; end
    valid_i = 1'b0;
    checks++; if (d !== 0) begin errs++; $display("FAIL div_done got=%0d pulses want=0", d); end
    checks++; if (start_cnt !== s) begin errs++; $display("FAIL div_start got=%0d want=%0d", start_cnt, s); end
  endtask

  task automatic test_mul;
    int lat; logic [31:0] res; logic st0, d1;
    run_op(3'b000, 32'h2, 32'h2, lat, res, st0, d1);
    checks++; if (st0 !== 1'b1) begin errs++; $display("FAIL mul_accept_stall got=%b want=1", st0); end
    checks++; if (lat !== 33) begin errs++; $display("FAIL mul_latency got=%0d want=33", lat); end
    checks++; if (res !== 32'h4) begin errs++; $display("FAIL mul_result got=%h want=00000004", res); end
    checks++; if (d1 !== 1'b0) begin errs++; $display("FAIL mul_done_width got=%b want=0", d1); end
  endtask

  task automatic test_mulh_mulhu;
    int lat; logic [31:0] res; logic st0, d1;
    run_op(3'b001, 32'hFFFFFFFE, 32'hFFFFFFF6, lat, res, st0, d1);
    checks++; if (lat !== 33) begin errs++; $display("FAIL mulh_latency got=%0d want=33", lat); end
    checks++; if (res !== 32'h0) begin errs++; $display("FAIL mulh_result got=%h want=00000000", res); end
    run_op(3'b011, 32'hFFFFFFFE, 32'hFFFFFFF6, lat, res, st0, d1);
    checks++; if (lat !== 33) begin errs++; $display("FAIL mulhu_latency got=%0d want=33", lat); end
    checks++; if (res !== 32'hFFFFFFF4) begin errs++; $display("FAIL mulhu_result got=%h want=fffffff4", res); end
  endtask

  task automatic test_hit;
    int lat, s; logic [31:0] res; logic st0, d1;
    s = start_cnt;
    run_op(3'b000, 32'hFFFFFFFE, 32'hFFFFFFF6, lat, res, st0, d1);
    checks++; if (lat !== 1) begin errs++; $display("FAIL hit_latency got=%0d want=1", lat); end
    checks++; if (res !== 32'h14) begin errs++; $display("FAIL hit_result got=%h want=00000014", res); end
    checks++; if (start_cnt !== s) begin errs++; $display("FAIL hit_start got=%0d want=%0d", start_cnt, s); end
    checks++; if (st0 !== 1'b1) begin errs++; $display("FAIL hit_accept_stall got=%b want=1", st0); end
    checks++; if (d1 !== 1'b0) begin errs++; $display("FAIL hit_done_width got=%b want=0", d1); end
  endtask

  task automatic test_mulhsu;
    int lat; logic [31:0] res; logic st0, d1;
    run_op(3'b010, 32'hFFFFFFFE, 32'h4, lat, res, st0, d1);
    checks++; if (lat !== 33) begin errs++; $display("FAIL mulhsu_latency got=%0d want=33", lat); end
    checks++; if (res !== 32'hFFFFFFFF) begin errs++; $display("FAIL mulhsu_result got=%h want=ffffffff", res); end
  endtask

  task automatic test_flush;
    int lat, d; logic [31:0] res; logic st0, d1;
    @(negedge clk);
    valid_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd3; rs2_i = 32'd5;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    checks++; if (stall_o !== 1'b1) begin errs++; $display("FAIL flush_calc_stall got=%b want=1", stall_o); end
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    checks++; if (stall_o !== 1'b0) begin errs++; $display("FAIL flush_stall got=%b want=0", stall_o); end
    d = 0;
    repeat (40) begin if (done_o !== 1'b0) d++; @(posedge clk); #1; end
    checks++; if (d !== 0) begin errs++; $display("FAIL flush_done got=%0d pulses want=0", d); end
    run_op(3'b000, 32'd3, 32'd5, lat, res, st0, d1);
    checks++; if (lat !== 33) begin errs++; $display("FAIL post_flush_latency got=%0d want=33", lat); end
    checks++; if (res !== 32'd15) begin errs++; $display("FAIL post_flush_result got=%h want=0000000f", res); end
  endtask

  task automatic test_reset_mid_calc;
    int lat; logic [31:0] res; logic st0, d1;
    @(negedge clk);
    valid_i = 1'b1; funct3_i = 3'b011; rs1_i = 32'd7; rs2_i = 32'd9;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    reset = 1'b1; flush_i = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; flush_i = 1'b0;
    checks++; if (stall_o !== 1'b0) begin errs++; $display("FAIL rst_mid_stall got=%b want=0", stall_o); end
    checks++; if (done_o !== 1'b0) begin errs++; $display("FAIL rst_mid_done got=%b want=0", done_o); end
    checks++; if (result_o !== 32'h0) begin errs++; $display("FAIL rst_mid_result got=%h want=00000000", result_o); end
    run_op(3'b000, 32'd3, 32'd5, lat, res, st0, d1);
    checks++; if (lat !== 33) begin errs++; $display("FAIL rst_cache_miss_latency got=%0d want=33", lat); end
    checks++; if (res !== 32'd15) begin errs++; $display("FAIL rst_cache_miss_result got=%h want=0000000f", res); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] res; logic st0, d1;
    run_op(3'b000, 32'd3, 32'd5, lat, res, st0, d1);
    checks++; if (lat !== 1) begin errs++; $display("FAIL b2b_hit_latency got=%0d want=1", lat); end
    checks++; if (res !== 32'd15) begin errs++; $display("FAIL b2b_hit_result got=%h want=0000000f", res); end
    run_op(3'b001, 32'h80000000, 32'h80000000, lat, res, st0, d1);
    checks++; if (lat !== 33) begin errs++; $display("FAIL minint_latency got=%0d want=33", lat); end
    checks++; if (res !== 32'h40000000) begin errs++; $display("FAIL minint_result got=%h want=40000000", res); end
    run_op(3'b001, 32'hFFFFFFFF, 32'h1, lat, res, st0, d1);
    checks++; if (res !== 32'hFFFFFFFF) begin errs++; $display("FAIL mulh_neg_result got=%h want=ffffffff", res); end
  endtask

  initial begin
    test_reset();
    test_divide_ignored();
    test_mul();
    test_mulh_mulhu();
    test_hit();
    test_mulhsu();
    test_flush();
    test_reset_mid_calc();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
